// File: rtl/data_io_pkg.sv
// Shared io-controller command codes, upload base addresses and fetch FSM
// state type for the data_io family of blocks.
package data_io_pkg;

  localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;
  localparam logic [7:0] UIO_FILE_RX     = 8'h56;
  localparam logic [7:0] UIO_FILE_RX_DAT = 8'h57;

  localparam logic [24:0] TAPE_BASE_DEFAULT = 25'h200000;
  localparam logic [24:0] ROM_BASE_DEFAULT  = 25'h40000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } fetch_state_t;

  function automatic logic [24:0] size_inc(input logic [24:0] s);
    return (s == '1) ? s : s + 25'd1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the io controller SPI pins into the clk domain: two-flop level
// synchronisers for ss/sdi and single-cycle rise/fall pulses for sck.
module spi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic ss,
  input  logic sdi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_s,
  output logic sdi_s
);

  logic [2:0] sck_q;
  logic [1:0] ss_q;
  logic [1:0] sdi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q <= '0;
      ss_q  <= '0;
      sdi_q <= '0;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      ss_q  <= {ss_q[0], ss};
      sdi_q <= {sdi_q[0], sdi};
    end
  end

  // Third sck stage exists only to compare against the settled second stage.
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ss_s     = ss_q[1];
  assign sdi_s    = sdi_q[1];

endmodule

// File: rtl/data_upload.sv
// Streams RAM contents to the io controller over SPI (command 0x57), with a
// one-byte prefetch buffer kept filled by a small RAM fetch FSM.
module data_upload
  import data_io_pkg::*;
#(
  parameter logic [24:0] TAPE_BASE = TAPE_BASE_DEFAULT,
  parameter logic [24:0] ROM_BASE  = ROM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        ss,
  input  logic        sdi,
  output logic        sdo,
  output logic        uploading,
  output logic [4:0]  index,
  output logic [24:0] size,
  output logic        underrun,
  output logic        rd,
  output logic [24:0] a,
  input  logic [7:0]  q,
  input  logic        rd_ack
);

  logic         sck_rise, sck_fall, ss_s, sdi_s;
  logic [3:0]   cnt;
  logic [6:0]   sr;
  logic [7:0]   cmd;
  logic [7:0]   rx_byte;
  logic [7:0]   shift;
  logic [7:0]   buffer;
  logic         buf_valid;
  logic [24:0]  addr;
  logic         stale;
  logic         drop;
  fetch_state_t state;

  logic idx_wr, start, stop, load, ack_use;

  spi_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .sck      (sck),
    .ss       (ss),
    .sdi      (sdi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_s     (ss_s),
    .sdi_s    (sdi_s)
  );

  assign rx_byte = {sr, sdi_s};
  assign ack_use = (state == ST_FETCH) && rd && rd_ack && !stale && !drop;

  always_comb begin
    idx_wr = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    load   = 1'b0;
    if (sck_rise && !ss_s) begin
      if (cnt == 4'd15) begin
        idx_wr = (cmd == UIO_FILE_INDEX);
        start  = (cmd == UIO_FILE_RX) && sdi_s;
        stop   = (cmd == UIO_FILE_RX) && !sdi_s;
      end
      load = uploading &&
             (((cnt == 4'd7) && (rx_byte == UIO_FILE_RX_DAT)) ||
              ((cnt == 4'd15) && (cmd == UIO_FILE_RX_DAT)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      sr        <= '0;
      cmd       <= '0;
      index     <= '0;
      uploading <= 1'b0;
      addr      <= '0;
      size      <= '0;
      underrun  <= 1'b0;
      shift     <= '0;
      sdo       <= 1'b0;
    end else begin
      if (ss_s) begin
        cnt <= '0;
      end else if (sck_rise) begin
        cnt <= (cnt == 4'd15) ? 4'd8 : cnt + 4'd1;
        sr  <= rx_byte[6:0];
        if (cnt == 4'd7) cmd <= rx_byte;
      end

      if (idx_wr) index <= rx_byte[4:0];

      if (start) begin
        uploading <= 1'b1;
        addr      <= (index == 5'd0) ? ROM_BASE : TAPE_BASE;
        size      <= '0;
        underrun  <= 1'b0;
      end else if (stop) begin
        uploading <= 1'b0;
      end

      if (load) begin
        if (buf_valid) begin
          shift <= buffer;
        end else if (ack_use) begin
          shift <= q;
        end else begin
          shift    <= '0;
          underrun <= 1'b1;
        end
        addr <= addr + 25'd1;
        size <= size_inc(size);
      end else if (sck_fall) begin
        shift <= {shift[6:0], 1'b0};
      end

      // cnt[3] masks the command phase so only data bits ever reach sdo.
      sdo <= !ss_s && uploading && cnt[3] && (cmd == UIO_FILE_RX_DAT) && shift[7];
    end
  end

  // rd drops for one cycle between requests so a never moves while rd is high;
  // stale marks an in-flight read whose address was overtaken by a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rd        <= 1'b0;
      a         <= '0;
      buffer    <= '0;
      buf_valid <= 1'b0;
      stale     <= 1'b0;
      drop      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_FETCH: begin
          if (rd) begin
            if (rd_ack) begin
              rd    <= 1'b0;
              stale <= 1'b0;
              drop  <= 1'b0;
              if (drop) begin
                state <= ST_IDLE;
              end else if (!stale && !load) begin
                buffer    <= q;
                buf_valid <= 1'b1;
                state     <= ST_FULL;
              end
            end else if (load) begin
              stale <= 1'b1;
            end
          end else if (!load) begin
            rd <= 1'b1;
            a  <= addr;
          end
        end
        ST_FULL: begin
          if (load) begin
            buf_valid <= 1'b0;
            state     <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (start) begin
        buf_valid <= 1'b0;
        drop      <= 1'b0;
        state     <= ST_FETCH;
        if (rd && !rd_ack) stale <= 1'b1;
      end else if (stop) begin
        buf_valid <= 1'b0;
        if (rd && !rd_ack) drop <= 1'b1;
        else state <= ST_IDLE;
      end
    end
  end

endmodule

// File: doc/data_upload.md
DATA_UPLOAD -- requirements
Module: data_upload

Interface
REQ-001 The module SHALL have parameter TAPE_BASE, 25'h200000, RAM start address for index!=0 uploads.
REQ-002 The module SHALL have parameter ROM_BASE, 25'h40000, RAM start address for index==0 uploads.
REQ-003 The module SHALL have port clk  input  1  sole clock; all state on posedge clk.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port sck  input  1  io controller SPI clock, asynchronous to clk, at most clk/8.
REQ-006 The module SHALL have port ss  input  1  SPI select, active low.
REQ-007 The module SHALL have port sdi  input  1  SPI data from controller.
REQ-008 The module SHALL have port sdo  output  1  SPI data to controller, MSB first.
REQ-009 The module SHALL have port uploading  output  1  upload session active.
REQ-010 The module SHALL have port index  output  5  menu index latched by command 0x55.
REQ-011 The module SHALL have port size  output  25  bytes sent this session.
REQ-012 The module SHALL have port underrun  output  1  sticky; byte requested before RAM data ready.
REQ-013 The module SHALL have port rd  output  1  RAM read request, held until rd_ack.
REQ-014 The module SHALL have port a  output  25  RAM address, stable while rd high.
REQ-015 The module SHALL have port q  input  8  RAM read data, valid with rd_ack.
REQ-016 The module SHALL have port rd_ack  input  1  single-cycle read completion.

Function
REQ-017 The module SHALL synchronise sck, ss and sdi through two flops; sck edges SHALL be detected from the second and third stages.
REQ-018 While synchronised ss is high, the bit counter SHALL be 0; each sck rise SHALL increment it 0..15, with 15 wrapping to 8.
REQ-019 On the rise at count 7, the command SHALL be latched from the 7 shifted bits plus sdi.
REQ-020 Command 0x55 at count 15 SHALL set index to the low 5 payload bits.
REQ-021 Command 0x56 at count 15 with sdi=1 SHALL set addr to ROM_BASE if index==0, else TAPE_BASE, clear size, clear underrun, clear buffer valid, set uploading, and start a fetch.
REQ-022 Command 0x56 at count 15 with sdi=0 SHALL clear uploading; an outstanding rd SHALL be held until rd_ack and its data discarded.
REQ-023 On the rise at count 7 or 15 when the latched-or-completing command is 0x57 and uploading=1, the module SHALL load the shift register from the buffer, clear buffer valid, increment addr and size, and start the next fetch.
REQ-024 If the buffer is invalid at load, the module SHALL load 8'h00 and set underrun; addr and size SHALL still advance.
REQ-025 If rd_ack coincides with a load, q SHALL be loaded directly and the buffer SHALL stay invalid.
REQ-026 Each sck fall SHALL shift the register left; sdo SHALL equal shift[7] within 4 clk of the load or fall edge, and SHALL be 0 when ss is high or uploading=0.
REQ-027 The fetch FSM SHALL have states IDLE (rd=0), FETCH (rd=1, a=addr), and FULL (buffer valid); FETCH SHALL go to FULL on rd_ack; FULL SHALL go to FETCH on load; any state SHALL go to IDLE on stop, after any pending ack.
REQ-028 addr SHALL wrap modulo 2^25, and size SHALL saturate at 25'h1FFFFFF.
REQ-029 Commands other than 0x55/0x56/0x57 SHALL be ignored, with sdo=0.

Reset
REQ-030 Reset SHALL asynchronously clear sdo, uploading, index, size, underrun, rd, a, the counter, the command, the shift register, buffer valid and the synchroniser flops, and SHALL force the FSM to IDLE.
REQ-031 Reset mid-fetch SHALL drop rd immediately; the RAM arbiter tolerates an abandoned request.

Structure
REQ-032 UIO_FILE_INDEX=0x55, UIO_FILE_RX=0x56, UIO_FILE_RX_DAT=0x57 and the base addresses SHALL reside in shared package data_io_pkg.
REQ-033 One sub-module, spi_sync_edge (2-flop synchroniser plus rise/fall pulses for sck, level outputs for ss and sdi), SHALL be instantiated.

Verification
REQ-034 Scenario 1: index=0, 0x56/0xFF, RAM 0x40000..0x40003 = A5 3C 00 FF, four 0x57 bytes -> sdo bytes A5 3C 00 FF, size=4, underrun=0.
REQ-035 Scenario 2: index=3, start session -> first rd shows a=0x200000.
REQ-036 Scenario 3: rd_ack delayed 200 clk and first 0x57 byte clocked at once -> byte 0x00, underrun=1, next byte = RAM[base+1].
REQ-037 Scenario 4: rd_ack in the same clk as a load -> sdo carries q, and the next rd follows within 2 clk.
REQ-038 Scenario 5: 0x56/0x00 while rd high -> rd stays high until ack, then IDLE, uploading=0, no further rd.
REQ-039 Scenario 6: reset asserted mid-byte -> all outputs 0 in the same cycle; a new session restarts at base.
